// File: rtl/serial2parallel_pkg.sv
// Shared definitions for the serial-to-parallel converter: FSM states and default word width.
package serial2parallel_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic {
    StIdle,
    StShift
  } s2p_state_e;

endpackage

// File: rtl/s2p_bit_counter.sv
// Bit position counter for one serial frame: load to 1 on frame start, increment per captured bit.
module s2p_bit_counter
  import serial2parallel_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(1);
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;
  // Terminal count: the next captured bit is the final bit of the frame.
  assign last  = (count_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial2parallel.sv
// LSB-first serial-to-parallel converter; a updates and end_conversion pulses once per full frame.
module serial2parallel
  import serial2parallel_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_start,
  input  logic              d,
  output logic              end_conversion,
  output logic [DATA_W-1:0] a
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  s2p_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              eoc_q, eoc_d;
  logic              cnt_load, cnt_inc, cnt_last;
  logic [CntW-1:0]   cnt;

  s2p_bit_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CntW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    a_d      = a_q;
    eoc_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (serial_start) begin
          shift_d  = DATA_W'(d);
          cnt_load = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        // Upper bits were cleared at frame start, so OR-ing places d at bit[cnt].
        shift_d = shift_q | (DATA_W'(d) << cnt);
        cnt_inc = 1'b1;
        if (cnt_last) begin
          a_d     = shift_d;
          eoc_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      a_q     <= '0;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      eoc_q   <= eoc_d;
    end
  end

  assign a              = a_q;
  assign end_conversion = eoc_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Directed and randomized frames checked against a word-level model of the converter.
module tb_serial2parallel;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          serial_start;
  logic          d;
  logic          end_conversion;
  logic [DW-1:0] a;

  int checks;
  int failures;
  logic [DW-1:0] exp_a;

  serial2parallel #(
    .DATA_W (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_start   (serial_start),
    .d              (d),
    .end_conversion (end_conversion),
    .a              (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends nbits of word LSB first; restart_bit >= 1 raises serial_start again mid-frame.
  task automatic send(input logic [DW-1:0] word, input int restart_bit, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      serial_start = (i == 0) || (i == restart_bit);
      d            = word[i];
      tick();
      if (i < DW - 1) begin
        chk("eoc_mid_frame", 32'(end_conversion), 32'd0);
        chk("a_hold_mid_frame", 32'(a), 32'(exp_a));
      end else begin
        exp_a = word;
        chk("eoc_done", 32'(end_conversion), 32'd1);
        chk("a_done", 32'(a), 32'(exp_a));
      end
    end
    serial_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      serial_start = 1'b0;
      d            = 1'($urandom_range(0, 1));
      tick();
      chk("eoc_idle", 32'(end_conversion), 32'd0);
      chk("a_idle", 32'(a), 32'(exp_a));
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    exp_a        = '0;
    rst_n        = 1'b0;
    serial_start = 1'b0;
    d            = 1'b0;
    #12;
    chk("reset_a", 32'(a), 32'd0);
    chk("reset_eoc", 32'(end_conversion), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single frame 0x4D, then a quiet gap proves the pulse is one cycle wide.
    send(8'h4D, -1, DW);
    idle(2);

    // Back-to-back 0x00 then 0xFF: second start lands in the end_conversion cycle.
    send(8'h00, -1, DW);
    send(8'hFF, -1, DW);
    idle(1);

    // Reset in the middle of 0xA5 discards it; a fresh start is then required.
    send(8'hA5, -1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    exp_a = '0;
    chk("midreset_a", 32'(a), 32'd0);
    chk("midreset_eoc", 32'(end_conversion), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(DW + 2);
    send(8'h3C, -1, DW);
    idle(1);

    // serial_start on bit 3 is ignored.
    send(8'h96, 3, DW);
    idle(1);

    // Frame 0x5A followed by 20 cycles of toggling d without a start.
    send(8'h5A, -1, DW);
    for (int i = 0; i < 20; i++) begin
      serial_start = 1'b0;
      d            = 1'(i % 2);
      tick();
      chk("toggle_eoc", 32'(end_conversion), 32'd0);
      chk("toggle_a", 32'(a), 32'h5A);
    end

    // Random frames with random gaps (including zero) and random spurious restarts.
    for (int f = 0; f < 40; f++) begin
      logic [DW-1:0] w;
      int rb;
      w  = DW'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW - 1)) : -1;
      send(w, rb, DW);
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
SERIAL2PARALLEL -- requirements
Module: serial2parallel

Interface
REQ-001 Parameter: DATA_W, default 8, parallel word width and bits per frame.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 serial_start  input  1  frame-start strobe; high in the same cycle as the first serial bit.
REQ-005 d  input  1  serial data bit, LSB first, one bit per clock.
REQ-006 end_conversion  output  1  one-cycle pulse marking a completed frame.
REQ-007 a  output  DATA_W  parallel word of the last completed frame.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (waiting) and SHIFT (collecting bits 1..DATA_W-1).
REQ-009 In IDLE, a rising edge with serial_start=1 SHALL capture d as bit 0, set the bit counter to 1 and enter SHIFT.
REQ-010 In IDLE with serial_start=0, d SHALL be ignored and all outputs SHALL hold.
REQ-011 In SHIFT, each rising edge SHALL capture d as bit[count] (LSB-first) and increment count.
REQ-012 On the edge capturing bit DATA_W-1, the block SHALL load the assembled word into a, assert end_conversion and return to IDLE.
REQ-013 Latency: a and end_conversion valid in the cycle after the edge sampling the last bit (DATA_W edges after the start edge inclusive).
REQ-014 end_conversion SHALL be high for exactly one clock cycle per completed frame.
REQ-015 a SHALL change only at frame completion and SHALL hold its value until the next completion; partial frames never appear on a.
REQ-016 serial_start asserted while in SHIFT SHALL be ignored; the current frame continues.
REQ-017 serial_start asserted in the cycle end_conversion is high (FSM in IDLE) SHALL start a new frame, allowing back-to-back frames with no gap.
REQ-018 The bit counter SHALL be ceil(log2(DATA_W))+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, count=0, shift register=0, a=0, end_conversion=0.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame; no end_conversion pulse is produced for it.
REQ-021 After rst_n deasserts, the first frame SHALL require a fresh serial_start.

Structure
REQ-022 A shared package SHALL hold the FSM state enumeration (IDLE, SHIFT) and the DATA_W default constant.
REQ-023 One sub-module, s2p_bit_counter (load/increment/terminal-count flag), SHALL be used; the shift register and FSM stay in the top.

Verification
REQ-024 Frame 0x4D (bits 1,0,1,1,0,0,1,0 in send order) with serial_start on bit 0 -> a=0x4D, end_conversion high for one cycle after bit 7.
REQ-025 Frames 0x00 then 0xFF, back-to-back (second start in end_conversion cycle) -> a=0x00 then 0xFF, two single-cycle pulses 8 cycles apart.
REQ-026 rst_n pulsed low after 4 bits of 0xA5 -> a=0x00, no pulse; following full frame 0x3C -> a=0x3C.
REQ-027 serial_start re-asserted on bit 3 of frame 0x96 -> ignored, a=0x96 after 8 bits.
REQ-028 d toggling with serial_start=0 for 20 cycles after a frame 0x5A -> a stays 0x5A, end_conversion stays 0.
